fsm_seq_tx: RTL and testbench

//  Transmit side of the 8-bit unlock-sequence link. On a start pulse, emits the unlock sequence
//  0x81,0x42,0x24,0x18, then hold_cnt beats of 0x1C, on a valid/ready byte bus.

---
 rtl/fsm_seq_pkg.sv | 39 +++
 rtl/fsm_seq_tx.sv | 149 ++++++++++++++
 tb/tb_fsm_seq_tx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the unlock-sequence transmitter and detector:
// one-hot state codes, beat bytes, detector status codes and the beat lookup.
package fsm_seq_pkg;

  localparam int          N_STATES = 7;
  localparam logic [6:0]  S_IDLE   = 7'b0000001;
  localparam logic [6:0]  S_B0     = 7'b0000010;
  localparam logic [6:0]  S_B1     = 7'b0000100;
  localparam logic [6:0]  S_B2     = 7'b0001000;
  localparam logic [6:0]  S_B3     = 7'b0010000;
  localparam logic [6:0]  S_HOLD   = 7'b0100000;
  localparam logic [6:0]  S_CHECK  = 7'b1000000;

  localparam logic [7:0]  BEAT0     = 8'h81;
  localparam logic [7:0]  BEAT1     = 8'h42;
  localparam logic [7:0]  BEAT2     = 8'h24;
  localparam logic [7:0]  BEAT3     = 8'h18;
  localparam logic [7:0]  BEAT_HOLD = 8'h1C;

  localparam logic [7:0]  STATUS_IDLE = 8'h01;
  localparam logic [7:0]  STATUS_S1   = 8'h03;
  localparam logic [7:0]  STATUS_S2   = 8'h05;
  localparam logic [7:0]  STATUS_S3   = 8'h09;
  localparam logic [7:0]  STATUS_OPEN = 8'h11;

  localparam logic [7:0]  IDLE_BYTE_DEFAULT = 8'h00;

  function automatic logic [7:0] beat_of(input logic [6:0] st, input logic [7:0] idle_byte);
    case (st)
      S_B0:    beat_of = BEAT0;
      S_B1:    beat_of = BEAT1;
      S_B2:    beat_of = BEAT2;
      S_B3:    beat_of = BEAT3;
      S_HOLD:  beat_of = BEAT_HOLD;
      default: beat_of = idle_byte;
    endcase
  endfunction

endpackage

// File: rtl/fsm_seq_tx.sv
// Unlock-sequence transmitter: 0x81,0x42,0x24,0x18 then hold_cnt x 0x1C on a valid/ready bus.
// Optional SEQ_TX_CHECK_EN adds a CHECK state that samples the detector status after the last beat.
module fsm_seq_tx
  import fsm_seq_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE     = IDLE_BYTE_DEFAULT,
  parameter int         CHECK_LAT     = 1,
  parameter logic [7:0] EXPECT_STATUS = STATUS_OPEN
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] hold_cnt,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
`ifdef SEQ_TX_CHECK_EN
  ,
  input  logic [7:0] status_in,
  output logic       err
`endif
);

  if (CHECK_LAT < 1 || CHECK_LAT > 15) begin : g_bad_lat
    $error("CHECK_LAT out of range 1..15");
  end

  logic [6:0] state_reg, state_next;
  logic [7:0] hold_reg, hold_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic       tx_valid_reg, tx_valid_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       hs;
  logic       last_beat;
`ifdef SEQ_TX_CHECK_EN
  logic [3:0] chk_reg, chk_next;
  logic       err_reg, err_next;
`endif

  assign hs = tx_valid_reg & tx_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= S_IDLE;
      hold_reg     <= '0;
      tx_data_reg  <= IDLE_BYTE;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef SEQ_TX_CHECK_EN
      chk_reg      <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
`ifdef SEQ_TX_CHECK_EN
      chk_reg      <= chk_next;
      err_reg      <= err_next;
`endif
    end
  end

  // Transitions; abort overrides everything, including a start in IDLE.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    done_next  = 1'b0;
    last_beat  = 1'b0;
`ifdef SEQ_TX_CHECK_EN
    chk_next   = chk_reg;
    err_next   = err_reg;
`endif
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          state_next = S_B0;
          hold_next  = hold_cnt;
`ifdef SEQ_TX_CHECK_EN
          err_next   = 1'b0;
`endif
        end
        S_B0: if (hs) state_next = S_B1;
        S_B1: if (hs) state_next = S_B2;
        S_B2: if (hs) state_next = S_B3;
        S_B3: if (hs) begin
          if (hold_reg != 8'd0) state_next = S_HOLD;
          else                  last_beat  = 1'b1;
        end
        S_HOLD: if (hs) begin
          // Counter stops at zero rather than wrapping.
          if (hold_reg <= 8'd1) begin
            hold_next = 8'd0;
            last_beat = 1'b1;
          end else begin
            hold_next = hold_reg - 8'd1;
          end
        end
`ifdef SEQ_TX_CHECK_EN
        S_CHECK: begin
          if (chk_reg <= 4'd1) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
            err_next   = (status_in != EXPECT_STATUS);
          end else begin
            chk_next = chk_reg - 4'd1;
          end
        end
`endif
        default: state_next = S_IDLE;
      endcase
      if (last_beat) begin
`ifdef SEQ_TX_CHECK_EN
        state_next = S_CHECK;
        chk_next   = 4'(CHECK_LAT);
`else
        state_next = S_IDLE;
        done_next  = 1'b1;
`endif
      end
    end
  end

  // Outputs are registered images of the next state.
  always_comb begin
    tx_data_next  = beat_of(state_next, IDLE_BYTE);
    tx_valid_next = (state_next & (S_B0 | S_B1 | S_B2 | S_B3 | S_HOLD)) != 7'd0;
    busy_next     = (state_next != S_IDLE);
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
`ifdef SEQ_TX_CHECK_EN
  assign err      = err_reg;
`endif

endmodule

// File: tb/tb_fsm_seq_tx.sv
// Self-checking bench for fsm_seq_tx: vector table, hand sequences for stall/abort/reset,
// and a beat scoreboard fed at start and drained on each handshake.
module tb_fsm_seq_tx;
  import fsm_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] hold_cnt = 8'd0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       done;
`ifdef SEQ_TX_CHECK_EN
  logic [7:0] status_in = 8'h00;
  logic       err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_beat = 0;
  logic [7:0] sb_q[$];

  fsm_seq_tx dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .hold_cnt (hold_cnt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
`ifdef SEQ_TX_CHECK_EN
    ,
    .status_in(status_in),
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       ready;
    logic [7:0] hold;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
    logic       push;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [7:0] h);
    sb_q.push_back(BEAT0);
    sb_q.push_back(BEAT1);
    sb_q.push_back(BEAT2);
    sb_q.push_back(BEAT3);
    for (int i = 0; i < int'(h); i++) sb_q.push_back(BEAT_HOLD);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, tx_valid, 1'b0);
    chk({name, "_data"},  tx_data,  8'h00);
    chk({name, "_busy"},  busy,     1'b0);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1'b1);
    chk_idle(name);
    step();
    chk({name, "_done_pulse"}, done, 1'b0);
    chk({name, "_sb_empty"}, sb_q.size(), 0);
  endtask

  // A beat transfers on the coming edge when valid&ready are high now and no abort/reset intervenes.
  always @(negedge clk) begin
    if (rstn && !abort && tx_valid && tx_ready) begin
      logic [7:0] exp_b;
      if (sb_q.size() == 0) begin
        chk("sb_extra_beat", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        exp_b = sb_q.pop_front();
        n_beat++;
        $display("beat %0d: data=%02h expected=%02h", n_beat, tx_data, exp_b);
        chk("sb_beat", tx_data, exp_b);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

`ifndef SEQ_TX_CHECK_EN
  vec_t vecs[20];
`endif

  initial begin
    logic [7:0] exp_seq[6];
    exp_seq[0] = 8'h81; exp_seq[1] = 8'h42; exp_seq[2] = 8'h24;
    exp_seq[3] = 8'h18; exp_seq[4] = 8'h1C; exp_seq[5] = 8'h1C;

    // Reset values
    @(posedge clk); #1;
    step();
    chk_idle("reset");
    chk("reset_done", done, 1'b0);
`ifdef SEQ_TX_CHECK_EN
    chk("reset_err", err, 1'b0);
`endif
    rstn = 1'b1;
    tx_ready = 1'b1;
    step();

`ifndef SEQ_TX_CHECK_EN
    // Tests 1/2, start in done cycle, start while busy
    vecs[0]  = '{1'b1, 1'b1, 8'd2, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h24, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h18, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'd0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h24, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h18, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'd1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 8'd9, 1'b1, 8'h24, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h18, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'd0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 20; v++) begin
      start    = vecs[v].start;
      tx_ready = vecs[v].ready;
      hold_cnt = vecs[v].hold;
      if (vecs[v].push) push_seq(vecs[v].hold);
      step();
      chk($sformatf("vec%0d_valid", v), tx_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_data", v),  tx_data,  vecs[v].exp_data);
      chk($sformatf("vec%0d_busy", v),  busy,     vecs[v].exp_busy);
      chk($sformatf("vec%0d_done", v),  done,     vecs[v].exp_done);
    end
    chk("table_sb_empty", sb_q.size(), 0);
`endif

    // Test 3: stall while 0x24 presented
    start = 1'b1; hold_cnt = 8'd0; tx_ready = 1'b1; push_seq(8'd0);
    step(); start = 1'b0;
    chk("stall_b0", tx_data, 8'h81);
    step(); chk("stall_b1", tx_data, 8'h42);
    step(); chk("stall_b2", tx_data, 8'h24);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_hold%0d_data", i), tx_data, 8'h24);
      chk($sformatf("stall_hold%0d_valid", i), tx_valid, 1'b1);
    end
    tx_ready = 1'b1;
    step(); chk("stall_b3", tx_data, 8'h18);
    wait_done("stall");

    // Test 4: abort during 2nd 0x1C of hold_cnt=5, start while busy ignored
    start = 1'b1; hold_cnt = 8'd5; push_seq(8'd5);
    for (int k = 0; k < 6; k++) begin
      step();
      start = (k == 0);
      hold_cnt = (k == 0) ? 8'd9 : 8'd0;
      chk($sformatf("abort_seq%0d", k), tx_data, exp_seq[k]);
      chk($sformatf("abort_busy%0d", k), busy, 1'b1);
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    chk_idle("abort");
    chk("abort_no_done", done, 1'b0);
    sb_q.delete();
    start = 1'b1; hold_cnt = 8'd3;
    step();
    chk_idle("abort_start");
    chk("abort_start_done", done, 1'b0);
    abort = 1'b0; start = 1'b0;
    step();
    chk_idle("abort_after");
    chk("abort_after_done", done, 1'b0);

    // Test 6: reset during B2, then a fresh sequence
    start = 1'b1; hold_cnt = 8'd3; push_seq(8'd3);
    step(); start = 1'b0;
    step();
    step(); chk("rst_b2", tx_data, 8'h24);
    rstn = 1'b0;
    step();
    chk_idle("rst_mid");
    chk("rst_mid_done", done, 1'b0);
    rstn = 1'b1;
    sb_q.delete();
    step();
    start = 1'b1; hold_cnt = 8'd1; push_seq(8'd1);
    step(); start = 1'b0;
    chk("rst_fresh_b0", tx_data, 8'h81);
    wait_done("rst_fresh");

`ifdef SEQ_TX_CHECK_EN
    // Status check: matching status, then mismatch, sticky until next accepted start
    status_in = STATUS_OPEN;
    start = 1'b1; hold_cnt = 8'd1; push_seq(8'd1);
    step(); start = 1'b0;
    wait_done("chk_ok");
    chk("chk_ok_err", err, 1'b0);
    status_in = STATUS_IDLE;
    start = 1'b1; push_seq(8'd1);
    step(); start = 1'b0;
    wait_done("chk_bad");
    chk("chk_bad_err", err, 1'b1);
    step(); step();
    chk("chk_sticky_err", err, 1'b1);
    status_in = STATUS_OPEN;
    start = 1'b1; push_seq(8'd1);
    step(); start = 1'b0;
    chk("chk_clear_err", err, 1'b0);
    wait_done("chk_again");
    chk("chk_again_err", err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
